// File: rtl/tvip_clock_divider_ctrl.sv
// tvip_clock_divider_ctrl: programmable glitch-free clock divider with
// start/stop sequencing, phase-boundary period updates and a wait-N-rises
// service on the generated clock.
// Optional build macro TVIP_CLOCK_DIVIDER_CTRL_CYCLE_COUNT_EN adds a 32-bit
// free-running count of generated rising edges (cycle_count).
module tvip_clock_divider_ctrl #(
  parameter int DIV_WIDTH  = 8,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_req,
  input  logic                  stop_req,
  input  logic [DIV_WIDTH-1:0]  half_period,
  input  logic                  period_update,
  output logic                  clk_out,
  output logic                  clk_out_n,
  output logic                  rise_pulse,
  output logic                  running,
  output logic                  cfg_err,
  input  logic                  wait_req,
  input  logic [WAIT_WIDTH-1:0] wait_cycles,
  output logic                  wait_busy,
`ifdef TVIP_CLOCK_DIVIDER_CTRL_CYCLE_COUNT_EN
  output logic                  wait_done,
  output logic [31:0]           cycle_count
`else
  output logic                  wait_done
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                state_q, state_d;
  logic                  clk_q, clk_d;
  logic                  clk_n_q;
  logic                  rise_q;
  logic                  err_q, err_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  act_q, act_d;
  logic [DIV_WIDTH-1:0]  pend_q, pend_d;
  logic                  pvld_q, pvld_d;
  logic                  toggle;
  logic                  hp_zero;

  logic                  wbusy_q, wbusy_d;
  logic                  wdone_q, wdone_d;
  logic [WAIT_WIDTH-1:0] wrem_q, wrem_d;

  assign hp_zero = (half_period == '0);
  // A phase boundary is reached when the phase counter runs out while active.
  assign toggle  = (state_q != IDLE) && (cnt_q == '0);

  // Next-state, phase counter and period bookkeeping.
  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (period_update && hp_zero) err_d = 1'b1;
        if (!stop_req && start_req) begin
          if (hp_zero) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            clk_d   = 1'b1;
            cnt_d   = half_period - 1'b1;
            act_d   = half_period;
            pvld_d  = 1'b0;
          end
        end
      end
      default: begin
        // Phase timing; a pending period takes effect at the boundary.
        if (toggle) begin
          clk_d = ~clk_q;
          if (pvld_q) begin
            act_d  = pend_q;
            cnt_d  = pend_q - 1'b1;
            pvld_d = 1'b0;
          end else begin
            cnt_d = act_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        // An update seen this cycle is held for the following boundary.
        if (period_update) begin
          if (hp_zero) begin
            err_d = 1'b1;
          end else begin
            pend_d = half_period;
            pvld_d = 1'b1;
          end
        end
        if (state_q == RUN) begin
          if (stop_req) begin
            if (clk_q) begin
              // Finish the high phase at full length before parking low.
              if (toggle) begin
                state_d = IDLE;
                cnt_d   = '0;
              end else begin
                state_d = STOPPING;
              end
            end else begin
              // Low phase may be cut short; output stays low.
              state_d = IDLE;
              clk_d   = 1'b0;
              cnt_d   = '0;
            end
          end
        end else begin
          if (stop_req) begin
            if (toggle) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (start_req) begin
            state_d = RUN;
          end else if (toggle) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  // Wait service: counts rises visible on rise_pulse once the wait is busy.
  always_comb begin
    wbusy_d = wbusy_q;
    wrem_d  = wrem_q;
    wdone_d = 1'b0;
    if (wbusy_q) begin
      if (rise_q) begin
        wrem_d = wrem_q - 1'b1;
        if (wrem_q == {{(WAIT_WIDTH-1){1'b0}}, 1'b1}) begin
          wbusy_d = 1'b0;
          wdone_d = 1'b1;
        end
      end
    end else if (wait_req) begin
      if (wait_cycles == '0) begin
        wdone_d = 1'b1;
      end else begin
        wbusy_d = 1'b1;
        wrem_d  = wait_cycles;
      end
    end
  end

  // Divider state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clk_q   <= 1'b0;
      clk_n_q <= 1'b1;
      rise_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      clk_n_q <= ~clk_d;
      rise_q  <= clk_d & ~clk_q;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
    end
  end

  // Wait service registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbusy_q <= 1'b0;
      wdone_q <= 1'b0;
      wrem_q  <= '0;
    end else begin
      wbusy_q <= wbusy_d;
      wdone_q <= wdone_d;
      wrem_q  <= wrem_d;
    end
  end

`ifdef TVIP_CLOCK_DIVIDER_CTRL_CYCLE_COUNT_EN
  logic [31:0] ccnt_q;
  // Free-running rise counter; survives stop, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ccnt_q <= '0;
    else if (rise_q) ccnt_q <= ccnt_q + 32'd1;
  end
  assign cycle_count = ccnt_q;
`endif

  assign clk_out    = clk_q;
  assign clk_out_n  = clk_n_q;
  assign rise_pulse = rise_q;
  assign running    = (state_q != IDLE);
  assign cfg_err    = err_q;
  assign wait_busy  = wbusy_q;
  assign wait_done  = wdone_q;

endmodule
